// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU-side definitions for the joypad input path
//
// Contents:
//   joypad_buttons_s         packed button vector, MSB first (Start..Right),
//                            bit-compatible with the raw/debounced 8-bit buses
//   JOY_RIGHT .. JOY_START   bit indices into that vector (0..7)
//   JOYPAD_DEBOUNCE_DEFAULT  default debounce length in clk_4mhz edges
package cpu_defs;

    typedef struct packed {
        logic start;
        logic select;
        logic b;
        logic a;
        logic down;
        logic up;
        logic left;
        logic right;
    } joypad_buttons_s;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_UP     = 2;
    localparam int JOY_DOWN   = 3;
    localparam int JOY_A      = 4;
    localparam int JOY_B      = 5;
    localparam int JOY_SELECT = 6;
    localparam int JOY_START  = 7;

    localparam int JOYPAD_DEBOUNCE_DEFAULT = 4096;

endpackage

// File: rtl/joypad_debounce_bit_m.sv
// joypad_debounce_bit_m: 2-flop synchronizer plus counting debouncer for one button
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   asynchronous raw button level, active-high pressed
//   state  out  accepted (debounced) level
//   rise   out  one-cycle pulse on the edge where state goes 0->1
module joypad_debounce_bit_m
    import cpu_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = JOYPAD_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic state,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          st_q, st_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized level agrees with the accepted one
    // clears the count, so a glitch never accumulates across bounces.
    // The count stops at CNT_MAX and is cleared on acceptance; it never wraps.
    always_comb begin
        meta_d = raw;
        sync_d = meta_q;
        st_d   = st_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        if (sync_q != st_q) begin
            if (cnt_q == CNT_MAX) begin
                st_d   = sync_q;
                rise_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            st_q   <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            st_q   <= st_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign state = st_q;
    assign rise  = rise_q;

endmodule

// File: rtl/joypad_input_m.sv
// joypad_input_m: debounced Game Boy buttons, P1 input nibble and joypad IRQ
//
// Ports:
//   clk          in   system clock (clk_4mhz)
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw buttons, active-high, [0]=Right .. [7]=Start
//   sel_dir_n    in   P14, active-low direction-group select
//   sel_btn_n    in   P15, active-low action-group select
//   btn_state    out  debounced buttons, active-high
//   btn_pressed  out  one-cycle pulse per accepted press
//   p1_nibble    out  registered P1[3:0], active-low
//   joypad_irq   out  one-cycle pulse when any P1[3:0] bit falls
module joypad_input_m
    import cpu_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = JOYPAD_DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_raw,
    input  logic       sel_dir_n,
    input  logic       sel_btn_n,
    output logic [7:0] btn_state,
    output logic [7:0] btn_pressed,
    output logic [3:0] p1_nibble,
    output logic       joypad_irq
);

    logic [3:0] nib;
    logic [3:0] p1_nibble_q, p1_nibble_d;
    logic       joypad_irq_q, joypad_irq_d;

    genvar i;
    for (i = 0; i < 8; i++) begin : g_bit
        joypad_debounce_bit_m #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .state(btn_state[i]),
            .rise (btn_pressed[i])
        );
    end

    // Selecting both groups wire-ANDs them, as on the real P1 matrix.
    // The IRQ fires on any 1->0 bit, so a select change that exposes an
    // already-held key also interrupts; releases never do.
    always_comb begin
        nib = 4'hF
            & ~({4{~sel_dir_n}} & btn_state[JOY_DOWN:JOY_RIGHT])
            & ~({4{~sel_btn_n}} & btn_state[JOY_START:JOY_A]);
        p1_nibble_d  = nib;
        joypad_irq_d = |(p1_nibble_q & ~nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_nibble_q  <= 4'hF;
            joypad_irq_q <= 1'b0;
        end else begin
            p1_nibble_q  <= p1_nibble_d;
            joypad_irq_q <= joypad_irq_d;
        end
    end

    assign p1_nibble  = p1_nibble_q;
    assign joypad_irq = joypad_irq_q;

endmodule

// File: tb/tb_joypad_input_m.sv
// tb_joypad_input_m: directed self-checking bench for joypad_input_m (DEBOUNCE_CYCLES=4)
module tb_joypad_input_m;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_raw = 8'h00;
    logic       sel_dir_n = 1'b1;
    logic       sel_btn_n = 1'b1;
    logic [7:0] btn_state;
    logic [7:0] btn_pressed;
    logic [3:0] p1_nibble;
    logic       joypad_irq;

    int total = 0;
    int bad = 0;
    logic [7:0] pr_or;
    logic       irq_or;

    joypad_input_m #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .sel_dir_n  (sel_dir_n),
        .sel_btn_n  (sel_btn_n),
        .btn_state  (btn_state),
        .btn_pressed(btn_pressed),
        .p1_nibble  (p1_nibble),
        .joypad_irq (joypad_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges while accumulating any press/IRQ activity seen.
    task automatic run(input int n);
        pr_or = 8'h00;
        irq_or = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            pr_or |= btn_pressed;
            irq_or |= joypad_irq;
        end
    endtask

    task automatic do_reset();
        btn_raw = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // reset with all keys held
        btn_raw = 8'hFF;
        tick();
        tick();
        check("rst_state", btn_state, 8'h00);
        check("rst_pressed", btn_pressed, 8'h00);
        check("rst_p1", {4'h0, p1_nibble}, 8'h0F);
        check("rst_irq", {7'h0, joypad_irq}, 8'h00);
        rst_n = 1'b1;
        run(5);
        check("rst_hold_state_e5", btn_state, 8'h00);
        check("rst_hold_pr_e5", pr_or, 8'h00);
        tick();
        check("rst_hold_state_e6", btn_state, 8'hFF);
        check("rst_hold_pr_e6", btn_pressed, 8'hFF);
        tick();
        check("rst_hold_pr_e7", btn_pressed, 8'h00);
        check("rst_hold_p1_nosel", {4'h0, p1_nibble}, 8'h0F);

        // glitch reject then 4-cycle accept on A
        do_reset();
        sel_dir_n = 1'b0;
        sel_btn_n = 1'b0;
        btn_raw = 8'h10;
        run(3);
        btn_raw = 8'h00;
        run(8);
        check("glitch_state", btn_state, 8'h00);
        check("glitch_pr", pr_or, 8'h00);
        check("glitch_irq", {7'h0, irq_or}, 8'h00);
        btn_raw = 8'h10;
        run(4);
        btn_raw = 8'h00;
        run(1);
        check("acc4_state_e5", btn_state, 8'h00);
        tick();
        check("acc4_state_e6", btn_state, 8'h10);
        check("acc4_pr_e6", btn_pressed, 8'h10);
        tick();
        check("acc4_p1_e7", {4'h0, p1_nibble}, 8'h0E);
        check("acc4_irq_e7", {7'h0, joypad_irq}, 8'h01);

        // press Start with action group selected
        do_reset();
        sel_dir_n = 1'b1;
        sel_btn_n = 1'b0;
        btn_raw = 8'h80;
        run(5);
        check("start_state_e5", btn_state, 8'h00);
        tick();
        check("start_state_e6", btn_state, 8'h80);
        check("start_pr_e6", btn_pressed, 8'h80);
        check("start_p1_e6", {4'h0, p1_nibble}, 8'h0F);
        check("start_irq_e6", {7'h0, joypad_irq}, 8'h00);
        tick();
        check("start_p1_e7", {4'h0, p1_nibble}, 8'h07);
        check("start_irq_e7", {7'h0, joypad_irq}, 8'h01);
        tick();
        check("start_irq_e8", {7'h0, joypad_irq}, 8'h00);
        check("start_p1_e8", {4'h0, p1_nibble}, 8'h07);
        btn_raw = 8'h00;
        run(8);
        check("start_rel_state", btn_state, 8'h00);
        check("start_rel_p1", {4'h0, p1_nibble}, 8'h0F);
        check("start_rel_irq", {7'h0, irq_or}, 8'h00);

        // select change exposes an already-held Down
        do_reset();
        sel_dir_n = 1'b1;
        sel_btn_n = 1'b1;
        btn_raw = 8'h08;
        run(8);
        check("exp_state", btn_state, 8'h08);
        check("exp_p1_pre", {4'h0, p1_nibble}, 8'h0F);
        check("exp_irq_pre", {7'h0, irq_or}, 8'h00);
        sel_dir_n = 1'b0;
        tick();
        check("exp_p1", {4'h0, p1_nibble}, 8'h07);
        check("exp_irq", {7'h0, joypad_irq}, 8'h01);
        tick();
        check("exp_irq_once", {7'h0, joypad_irq}, 8'h00);

        // both groups: Right + B
        do_reset();
        sel_dir_n = 1'b0;
        sel_btn_n = 1'b0;
        btn_raw = 8'h21;
        run(8);
        check("both_state", btn_state, 8'h21);
        check("both_p1", {4'h0, p1_nibble}, 8'h0C);
        sel_dir_n = 1'b1;
        tick();
        check("btn_only_p1", {4'h0, p1_nibble}, 8'h0D);
        check("btn_only_irq", {7'h0, joypad_irq}, 8'h00);
        sel_dir_n = 1'b0;
        tick();
        check("reexp_p1", {4'h0, p1_nibble}, 8'h0C);
        check("reexp_irq", {7'h0, joypad_irq}, 8'h01);
        sel_btn_n = 1'b1;
        tick();
        check("dir_only_p1", {4'h0, p1_nibble}, 8'h0E);
        check("dir_only_irq", {7'h0, joypad_irq}, 8'h00);
        sel_dir_n = 1'b1;
        tick();
        check("nosel_p1", {4'h0, p1_nibble}, 8'h0F);

        // reset mid-debounce of Left
        do_reset();
        btn_raw = 8'h02;
        run(3);
        rst_n = 1'b0;
        #1;
        check("mid_state", btn_state, 8'h00);
        check("mid_p1", {4'h0, p1_nibble}, 8'h0F);
        check("mid_irq", {7'h0, joypad_irq}, 8'h00);
        run(3);
        check("mid_pr", pr_or, 8'h00);
        check("mid_state_held", btn_state, 8'h00);
        rst_n = 1'b1;
        run(5);
        check("mid_rel_state_e5", btn_state, 8'h00);
        check("mid_rel_pr_e5", pr_or, 8'h00);
        tick();
        check("mid_rel_state_e6", btn_state, 8'h02);
        check("mid_rel_pr_e6", btn_pressed, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
